// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 op encodings, FSM state encoding and iteration constants.
package mdu_seq_pkg;

  localparam int MDU_STEPS = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } f3_op_m_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/mdu_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module mdu_div_step (
  input  logic [32:0] rem_in,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;

  assign shifted = {rem_in, dividend_bit};
  assign q_bit   = shifted >= {2'b00, divisor};
  assign rem_out = 33'(shifted - (q_bit ? {2'b00, divisor} : 34'd0));

endmodule

// File: rtl/mdu_seq.sv
// RV32M multiply/divide sequencer with valid/ready handshakes on both sides.
// Define MDU_FAST_MUL_EN for single-cycle multiplies via a combinational product.
//
// state | meaning
// IDLE  | no operation held
// CALC  | iterating (divide or shift-add multiply)
// DONE  | result held until out_ready
module mdu_seq
  import mdu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [2:0]  funct3_q;
  logic        sign_q;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [32:0] rem;
  logic [31:0] result_q;

  logic        accept;
  logic        signed_a, signed_b, neg_a, neg_b, sign_in;
  logic [31:0] mag_a, mag_b;
  logic        special;
  logic [31:0] special_res;
  logic        fast_hit;
  logic [31:0] fast_res;

  assign in_ready  = rst_n && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      F3_MULHSU: signed_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a   = signed_a & a[31];
  assign neg_b   = signed_b & b[31];
  assign mag_a   = neg_a ? neg32(a) : a;
  assign mag_b   = neg_b ? neg32(b) : b;
  // Remainder follows the dividend's sign; quotient and products the xor.
  assign sign_in = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (funct3[2]) begin
      if (b == 32'd0) begin
        special     = 1'b1;
        special_res = funct3[1] ? a : 32'hFFFF_FFFF;
      end else if (!funct3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        special     = 1'b1;
        special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [63:0] fast_prod, fast_prod_s;
  assign fast_prod   = {32'd0, mag_a} * {32'd0, mag_b};
  assign fast_prod_s = sign_in ? (~fast_prod + 64'd1) : fast_prod;
  assign fast_hit    = ~funct3[2];
  assign fast_res    = (funct3[1:0] == 2'b00) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  logic [32:0] rem_step;
  logic        q_bit;
  logic [32:0] mul_sum;
  logic [63:0] acc_nxt;
  logic [31:0] div_val, div_res, mul_res, fix_res;
  logic [63:0] prod;

  mdu_div_step u_div_step (
    .rem_in       (rem),
    .dividend_bit (acc[31]),
    .divisor      (opnd),
    .rem_out      (rem_step),
    .q_bit        (q_bit)
  );

  // Divide shifts quotient bits into acc[31:0]; multiply shifts the product right.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign acc_nxt = funct3_q[2] ? {acc[63:32], acc[30:0], q_bit} : {mul_sum, acc[31:1]};

  assign div_val = funct3_q[1] ? rem_step[31:0] : acc_nxt[31:0];
  assign div_res = sign_q ? neg32(div_val) : div_val;
  assign prod    = sign_q ? (~acc_nxt + 64'd1) : acc_nxt;
  assign mul_res = (funct3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  assign fix_res = funct3_q[2] ? div_res : mul_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      funct3_q <= '0;
      sign_q   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      result_q <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else if (accept) begin
      funct3_q <= funct3;
      sign_q   <= sign_in;
      count    <= 6'(MDU_STEPS - 1);
      rem      <= '0;
      if (funct3[2]) begin
        opnd <= mag_b;
        acc  <= {32'd0, mag_a};
      end else begin
        opnd <= mag_a;
        acc  <= {32'd0, mag_b};
      end
      if (special) begin
        result_q <= special_res;
        state    <= ST_DONE;
      end else if (fast_hit) begin
        result_q <= fast_res;
        state    <= ST_DONE;
      end else begin
        state <= ST_CALC;
      end
    end else begin
      case (state)
        ST_CALC: begin
          acc <= acc_nxt;
          if (funct3_q[2]) rem <= rem_step;
          if (count == 6'd0) begin
            result_q <= fix_res;
            state    <= ST_DONE;
          end else begin
            count <= count - 6'd1;
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: the driver queues hand-computed results,
// a negedge monitor pops and compares them on each output handshake.
module tb_mdu_seq;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  mdu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_edge;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   vseen = 1'b0;
  int   vedge = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp_res, input int lat);
    exp_t e;
    funct3   = f;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res      = exp_res;
        e.lat      = lat;
        e.acc_edge = edge_cnt + 1;
        e.name     = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s accept: in_ready stayed 0, expected 1", name);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n || !out_valid) begin
      vseen = 1'b0;
    end else begin
      if (!vseen) begin
        vseen = 1'b1;
        vedge = edge_cnt;
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: out_valid=1 result=%h, expected no output", result);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, " result"}, result, mon_e.res);
          check({mon_e.name, " latency"}, 32'(vedge - mon_e.acc_edge + 1), 32'(mon_e.lat));
        end
        vseen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    issue("div -7/2",       DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    issue("rem -7/2",       REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    issue("divu 5/0",       DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    issue("remu 5/0",       REMU,   32'd5,         32'd0,         32'd5,         1);
    issue("div ovf",        DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue("rem ovf",        REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    issue("mulh -1*2",      MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, ML);
    issue("mulhsu -1*2",    MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, ML);
    issue("mulhu",          MULHU,  32'hFFFF_FFFF, 32'd2,         32'd1,         ML);
    issue("mul",            MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, ML);
    issue("mul 0x12345678", MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, ML);
    issue("mulhu 2^31^2",   MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
    issue("mulh 2^31^2",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
    issue("div 7/-2",       DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    issue("rem 7/-2",       REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    issue("divu big/2",     DIVU,   32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33);
    wait_drain(200);

    // Consumer stall, then same-cycle consume and accept.
    out_ready = 1'b0;
    issue("divu 9/3", DIVU, 32'd9, 32'd3, 32'd3, 33);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("stall out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall result", result, 32'd3);
      check("stall in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33);
    wait_drain(200);

    // Flush mid-divide.
    issue("div flushed", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    issue("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 33);
    wait_drain(200);

    // in_valid coincident with flush is dropped.
    funct3   = DIVU;
    a        = 32'd5;
    b        = 32'd0;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush drop out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("flush drop idle", 32'(out_valid), 32'd0);

    // Reset mid-divide.
    issue("div reset", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midreset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    issue("rem after reset", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    wait_drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
